// File: rtl/icache_assoc_if.sv
// icache_assoc_if: fetch-side and memory-side signals of the instruction cache
interface icache_assoc_if;
  logic        rdy;
  logic        flush_i;
  logic        fetch_req_i;
  logic [31:0] fetch_pc_i;
  logic        hit_o;
  logic [31:0] inst_o;
  logic        busy_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_valid_i;
  logic [31:0] mem_data_i;
  modport slave (
    input  rdy, flush_i, fetch_req_i, fetch_pc_i, mem_valid_i, mem_data_i,
    output hit_o, inst_o, busy_o, mem_req_o, mem_addr_o
  );
  modport master (
    output rdy, flush_i, fetch_req_i, fetch_pc_i, mem_valid_i, mem_data_i,
    input  hit_o, inst_o, busy_o, mem_req_o, mem_addr_o
  );
endinterface

// File: rtl/icache_assoc.sv
// icache_assoc: 2-way set-associative instruction cache with critical-word forwarding (ports: clk, rst, bus.slave)
module icache_assoc #(
  parameter int SET_BITS = 6,
  parameter int OFF_BITS = 2,
  parameter int TAG_BITS = 10
) (
  input logic           clk,
  input logic           rst,
  icache_assoc_if.slave bus
);
  localparam int SETS  = 1 << SET_BITS;
  localparam int WORDS = 1 << OFF_BITS;
  localparam int LO    = OFF_BITS + 2;
  localparam int TLO   = SET_BITS + OFF_BITS + 2;
  typedef enum logic {IDLE, REFILL} state_t;
  state_t state_q, state_d;
  logic [SETS-1:0]     v0_q, v1_q, lru_q;
  logic [TAG_BITS-1:0] tag_q [2][SETS];
  logic [31:0]         data_q [2][SETS][WORDS];
  logic [31:0]         base_q;
  logic [SET_BITS-1:0] idx_q;
  logic [TAG_BITS-1:0] rtag_q;
  logic                way_q, fpend_q;
  logic [OFF_BITS-1:0] k_q;
  logic [OFF_BITS-1:0] off;
  logic [SET_BITS-1:0] idx;
  logic [TAG_BITS-1:0] tag;
  logic h0, h1, live, idle, lookup, ihit, miss, beat, last, fwd, vic, unused_pc;
  assign off       = bus.fetch_pc_i[LO-1:2];
  assign idx       = bus.fetch_pc_i[TLO-1:LO];
  assign tag       = bus.fetch_pc_i[TLO+TAG_BITS-1:TLO];
  assign unused_pc = ^{bus.fetch_pc_i[31:TLO+TAG_BITS], bus.fetch_pc_i[1:0]};
  assign h0     = v0_q[idx] && tag_q[0][idx] == tag;
  assign h1     = v1_q[idx] && tag_q[1][idx] == tag;
  assign live   = bus.rdy && !rst;
  assign idle   = state_q == IDLE;
  assign lookup = live && idle && bus.fetch_req_i && !bus.flush_i;
  assign ihit   = lookup && (h0 || h1);
  assign miss   = lookup && !(h0 || h1);
  assign beat   = live && !idle && bus.mem_valid_i;
  assign last   = k_q == {OFF_BITS{1'b1}};
  assign fwd    = beat && bus.fetch_req_i && tag == rtag_q && idx == idx_q && off == k_q;
  assign vic    = !v0_q[idx] ? 1'b0 : !v1_q[idx] ? 1'b1 : lru_q[idx];
  assign bus.hit_o      = ihit || fwd;
  assign bus.inst_o     = ihit ? data_q[h1][idx][off] : fwd ? bus.mem_data_i : '0;
  assign bus.busy_o     = !idle && !rst;
  assign bus.mem_req_o  = !idle && !rst;
  assign bus.mem_addr_o = base_q | 32'({k_q, 2'b00});
  always_comb begin
    state_d = miss ? REFILL : (beat && last) ? IDLE : state_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      v0_q    <= '0;
      v1_q    <= '0;
      lru_q   <= '0;
      k_q     <= '0;
      fpend_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (live && idle && bus.flush_i) begin
        v0_q  <= '0;
        v1_q  <= '0;
        lru_q <= '0;
      end
      if (ihit) lru_q[idx] <= !h1;
      if (miss) begin
        base_q <= bus.fetch_pc_i & ~32'(WORDS * 4 - 1);
        idx_q  <= idx;
        rtag_q <= tag;
        way_q  <= vic;
        k_q    <= '0;
      end
      if (live && !idle && bus.flush_i) fpend_q <= 1'b1;
      if (beat) begin
        data_q[way_q][idx_q][k_q] <= bus.mem_data_i;
        k_q <= k_q + 1'b1;
        if (last) begin
          fpend_q <= 1'b0;
          if (fpend_q || bus.flush_i) begin
            v0_q  <= '0;
            v1_q  <= '0;
            lru_q <= '0;
          end else begin
            tag_q[way_q][idx_q] <= rtag_q;
            if (way_q) v1_q[idx_q] <= 1'b1;
            else v0_q[idx_q] <= 1'b1;
            lru_q[idx_q] <= !way_q;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_icache_assoc.sv
// tb_icache_assoc: randomized fetch traffic against a set/way/LRU reference model of the cache
module tb_icache_assoc;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  icache_assoc_if bus();
  icache_assoc dut (.clk(clk), .rst(rst), .bus(bus));
  int n_vec = 0;
  int n_err = 0;
  bit        mv   [2][64];
  bit [9:0]  mt   [2][64];
  bit [31:0] md   [2][64][4];
  bit        mlru [64];
  task automatic check(input string t, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", t, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic bit [31:0] memw(input bit [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'hDEADBEEF;
  endfunction
  task automatic clear_model();
    for (int s = 0; s < 64; s++) begin
      mv[0][s] = 0;
      mv[1][s] = 0;
      mlru[s]  = 0;
    end
  endtask
  function automatic int find_way(input bit [31:0] pc);
    for (int w = 0; w < 2; w++)
      if (mv[w][pc[9:4]] && mt[w][pc[9:4]] == pc[19:10]) return w;
    return -1;
  endfunction
  task automatic fetch(input bit [31:0] pc, input bit stall, input bit fl);
    int s = int'(pc[9:4]);
    int o = int'(pc[3:2]);
    int w = find_way(pc);
    bit vic;
    bit fpend = 0;
    bit [31:0] base = pc & ~32'hF;
    bit [31:0] d;
    bus.fetch_req_i = 1;
    bus.fetch_pc_i  = pc;
    @(negedge clk);
    check("lookup_hit", 32'(bus.hit_o), 32'(w >= 0));
    check("lookup_inst", bus.inst_o, w >= 0 ? md[w][s][o] : 32'h0);
    check("idle_req", 32'(bus.mem_req_o), 0);
    if (w >= 0) begin
      mlru[s] = (w == 0);
      tick();
      bus.fetch_req_i = 0;
      return;
    end
    vic = !mv[0][s] ? 1'b0 : !mv[1][s] ? 1'b1 : mlru[s];
    tick();
    for (int k = 0; k < 4; k++) begin
      int waits = $urandom_range(0, 2);
      repeat (waits) begin
        @(negedge clk);
        check("wait_req", 32'(bus.mem_req_o), 1);
        check("wait_addr", bus.mem_addr_o, base + 32'(4 * k));
        check("wait_hit", 32'(bus.hit_o), 0);
        tick();
      end
      if (stall && k == 1) begin
        bus.rdy         = 0;
        bus.mem_valid_i = 1;
        bus.mem_data_i  = 32'hBAD0BAD0;
        repeat (3) begin
          @(negedge clk);
          check("stall_req", 32'(bus.mem_req_o), 1);
          check("stall_addr", bus.mem_addr_o, base + 32'(4 * k));
          check("stall_hit", 32'(bus.hit_o), 0);
          tick();
        end
        bus.rdy         = 1;
        bus.mem_valid_i = 0;
      end
      d = memw(base + 32'(4 * k));
      bus.mem_valid_i = 1;
      bus.mem_data_i  = d;
      if (fl && k == 1) begin
        bus.flush_i = 1;
        fpend = 1;
      end
      @(negedge clk);
      check("beat_addr", bus.mem_addr_o, base + 32'(4 * k));
      check("beat_busy", 32'(bus.busy_o), 1);
      check("fwd_hit", 32'(bus.hit_o), 32'(k == o));
      check("fwd_inst", bus.inst_o, k == o ? d : 32'h0);
      md[vic][s][k] = d;
      tick();
      bus.mem_valid_i = 0;
      bus.flush_i     = 0;
    end
    if (fpend) clear_model();
    else begin
      mv[vic][s] = 1;
      mt[vic][s] = pc[19:10];
      mlru[s]    = !vic;
    end
    bus.fetch_req_i = !fpend;
    @(negedge clk);
    check("done_req", 32'(bus.mem_req_o), 0);
    check("done_busy", 32'(bus.busy_o), 0);
    check("first_hit", 32'(bus.hit_o), 32'(!fpend));
    check("first_inst", bus.inst_o, fpend ? 32'h0 : md[vic][s][o]);
    tick();
    bus.fetch_req_i = 0;
  endtask
  task automatic flush_idle(input bit [31:0] pc);
    bus.fetch_req_i = 1;
    bus.fetch_pc_i  = pc;
    bus.flush_i     = 1;
    @(negedge clk);
    check("flush_hit", 32'(bus.hit_o), 0);
    check("flush_req", 32'(bus.mem_req_o), 0);
    tick();
    bus.flush_i     = 0;
    bus.fetch_req_i = 0;
    clear_model();
    @(negedge clk);
    check("flush_after_busy", 32'(bus.busy_o), 0);
    check("flush_after_req", 32'(bus.mem_req_o), 0);
    tick();
  endtask
  task automatic rdy_low_idle(input bit [31:0] pc);
    bus.rdy         = 0;
    bus.fetch_req_i = 1;
    bus.fetch_pc_i  = pc;
    @(negedge clk);
    check("rdy0_hit", 32'(bus.hit_o), 0);
    check("rdy0_inst", bus.inst_o, 0);
    check("rdy0_busy", 32'(bus.busy_o), 0);
    tick();
    bus.rdy         = 1;
    bus.fetch_req_i = 0;
  endtask
  task automatic reset_mid_refill(input bit [31:0] pc);
    bus.fetch_req_i = 1;
    bus.fetch_pc_i  = pc;
    @(negedge clk);
    check("rstm_miss", 32'(bus.hit_o), 0);
    tick();
    bus.mem_valid_i = 1;
    bus.mem_data_i  = memw(pc & ~32'hF);
    tick();
    bus.mem_valid_i = 0;
    rst = 1;
    @(negedge clk);
    check("rstm_req", 32'(bus.mem_req_o), 0);
    check("rstm_busy", 32'(bus.busy_o), 0);
    check("rstm_hit", 32'(bus.hit_o), 0);
    tick();
    rst = 0;
    bus.fetch_req_i = 0;
    clear_model();
    @(negedge clk);
    check("rstm_after_req", 32'(bus.mem_req_o), 0);
    check("rstm_after_busy", 32'(bus.busy_o), 0);
    tick();
  endtask
  initial begin
    bus.rdy         = 1;
    bus.flush_i     = 0;
    bus.fetch_req_i = 1;
    bus.fetch_pc_i  = 32'h1000;
    bus.mem_valid_i = 0;
    bus.mem_data_i  = 0;
    clear_model();
    repeat (2) tick();
    @(negedge clk);
    check("rst_hit", 32'(bus.hit_o), 0);
    check("rst_inst", bus.inst_o, 0);
    check("rst_req", 32'(bus.mem_req_o), 0);
    check("rst_busy", 32'(bus.busy_o), 0);
    tick();
    bus.fetch_req_i = 0;
    rst = 0;
    tick();
    fetch(32'h1000, 0, 0);
    fetch(32'h1008, 0, 0);
    fetch(32'h2000, 0, 0);
    fetch(32'h1000, 0, 0);
    fetch(32'h3000, 0, 0);
    fetch(32'h1000, 0, 0);
    fetch(32'h2000, 0, 0);
    fetch(32'h6000, 0, 1);
    fetch(32'h1000, 0, 0);
    fetch(32'h7004, 1, 0);
    fetch(32'h7004, 0, 0);
    flush_idle(32'h9000);
    fetch(32'h7004, 0, 0);
    flush_idle(32'h7004);
    reset_mid_refill(32'h5000);
    fetch(32'h5000, 0, 0);
    rdy_low_idle(32'h5000);
    fetch(32'h5004, 0, 0);
    repeat (250) begin
      int op = $urandom_range(0, 19);
      bit [11:0] hi = ($urandom_range(0, 3) == 0) ? 12'($urandom) : 12'h0;
      bit [31:0] pc = {hi, 10'($urandom_range(0, 4)), 6'($urandom_range(0, 3)),
                       2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      if (op == 0) flush_idle(pc);
      else if (op == 1) rdy_low_idle(pc);
      else fetch(pc, $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/icache_assoc.md
ICACHE_ASSOC -- requirements
Module: icache_assoc

Interface
REQ-001 Parameter SET_BITS, default 6, log2 of set count (64 sets).
REQ-002 Parameter OFF_BITS, default 2, log2 of 32-bit words per line (4 words).
REQ-003 Parameter TAG_BITS, default 10, stored tag width.
REQ-004 Reset rst, synchronous, active-high; clock clk.
REQ-005 clk  in  1  clock, all state updates on rising edge.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 rdy  in  1  global ready; 0 freezes all state.
REQ-008 flush_i  in  1  invalidate entire cache.
REQ-009 fetch_req_i  in  1  fetch request valid.
REQ-010 fetch_pc_i  in  32  fetch byte address.
REQ-011 hit_o  out  1  inst_o valid this cycle.
REQ-012 inst_o  out  32  fetched instruction.
REQ-013 busy_o  out  1  refill in progress.
REQ-014 mem_req_o  out  1  word read request to memory controller.
REQ-015 mem_addr_o  out  32  word-aligned request address.
REQ-016 mem_valid_i  in  1  requested word returned.
REQ-017 mem_data_i  in  32  returned word.

Function
REQ-018 Address split SHALL be: offset = pc[OFF_BITS+1:2], index = pc[SET_BITS+OFF_BITS+1:OFF_BITS+2], tag = next TAG_BITS bits; pc[1:0] and higher bits ignored.
REQ-019 Organisation SHALL be 2-way set-associative; per set per way: valid bit, tag, 2^OFF_BITS data words; per set: one LRU bit naming the way to replace next.
REQ-020 FSM states SHALL be IDLE and REFILL; busy_o = (state == REFILL).
REQ-021 IDLE lookup SHALL be combinational: hit_o=1 and inst_o=matching word same cycle when fetch_req_i, rdy, and a valid way tag matches; otherwise hit_o=0, inst_o=0.
REQ-022 On an IDLE hit the LRU bit of the set SHALL be set to the other way at clock edge.
REQ-023 On an IDLE miss (fetch_req_i, no hit, no flush_i) the block SHALL latch line base (pc with offset and bits[1:0] zeroed), index, tag, requested offset, and victim way, and enter REFILL next cycle.
REQ-024 Victim SHALL be way 0 if invalid, else way 1 if invalid, else the way named by LRU.
REQ-025 In REFILL mem_req_o SHALL be 1 with mem_addr_o = base + 4*k, k = 0..2^OFF_BITS-1 ascending; one outstanding request; k advances on each mem_valid_i.
REQ-026 Each mem_valid_i SHALL write mem_data_i into victim way word k.
REQ-027 Critical-word forward: when mem_valid_i delivers word k and fetch_req_i addresses the same line tag/index with offset k, hit_o=1, inst_o=mem_data_i that cycle; otherwise hit_o=0 throughout REFILL.
REQ-028 On the last word the victim way SHALL be marked valid with the latched tag, LRU set to the other way, FSM to IDLE; first hit possible the following cycle.
REQ-029 mem_req_o SHALL deassert the cycle after the last mem_valid_i.
REQ-030 flush_i in IDLE SHALL clear all valid and LRU bits at the edge; hit_o forced 0 that cycle, no refill started.
REQ-031 flush_i in REFILL SHALL set a pending flag; refill completes without marking the line valid, then all valid/LRU bits clear on the completion edge.
REQ-032 rdy=0 SHALL freeze FSM, counters, arrays, LRU; hit_o=0; mem_req_o/mem_addr_o hold; mem_valid_i ignored.

Reset
REQ-033 On rst: all valid and LRU bits 0, FSM IDLE, k=0, flush pending 0; data/tag arrays not reset.
REQ-034 While rst=1: hit_o=0, inst_o=0, mem_req_o=0, busy_o=0; rst mid-refill aborts the refill, nothing marked valid.

Verification
REQ-035 Reset, fetch 0x0000_1000 -> mem_addr_o 0x1000,0x1004,0x1008,0x100C; word at 0x1000 forwarded hit_o=1; after fill, fetch 0x1008 hits same cycle with third word.
REQ-036 Fill 0x1000 then 0x2000 (set 0, tags 4 and 8) -> both hit; hit 0x1000, then miss 0x3000 -> 0x2000 evicted, 0x1000 still hits.
REQ-037 flush_i during second word of refill -> refill finishes 4 requests, then 0x1000 misses again.
REQ-038 rdy=0 for 3 cycles mid-refill with mem_valid_i pulsed -> no word consumed, mem_addr_o unchanged, refill resumes identically.
REQ-039 rst asserted mid-refill -> mem_req_o=0 next cycle, busy_o=0, subsequent fetch of same line misses.
REQ-040 flush_i and missing fetch_req_i same IDLE cycle -> hit_o=0, no mem_req_o, all lines invalid next cycle.
